hram_target: RTL



---
 rtl/hram_target.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/hram_target.sv
// Device-side responder for the DDR octal-SPI PSRAM link in x8 mode.
// It registers CE/CK/ADQ/DQS, decodes each CK transition and serves reads and writes from a byte array.

module hram_target #(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        ck,
  input  logic [15:0] adq_i,
  output logic [7:0]  adq_o,
  output logic        adq_oe,
  input  logic [1:0]  dqs_i,
  output logic [1:0]  dqs_o,
  output logic        dqs_oe,
  output logic        cmd_err,
  output logic [3:0]  state
);

  localparam int CNT_W = 8;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CMD    = 4'd1,
    ADDR   = 4'd2,
    WDATA  = 4'd3,
    RLAT   = 4'd4,
    RDATA  = 4'd5,
    IGNORE = 4'd6
  } state_t;

  state_t            state_q;
  logic              ceIn_q;
  logic              ckIn_q;
  logic              ckPrev_q;
  logic              maskIn_q;
  logic [7:0]        adqIn_q;
  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;
  logic [31:0]       addr_q;
  logic [31:0]       addr_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              isWrite_q;
  logic              badCmd_q;
  logic              ceSeenHigh_q;
  logic [7:0]        adqOut_q;
  logic [1:0]        dqsOut_q;
  logic              adqOe_q;
  logic              dqsOe_q;
  logic              cmdErr_q;
  logic              ckEdge;
  logic              memWe;
  logic [7:0]        memRd;
  logic              unused_bits;

  // The pad inputs are not reset so that a CE held low through reset is seen as low, not as a fresh rise.
  always_ff @(posedge clk) begin
    ceIn_q   <= ce;
    ckIn_q   <= ck;
    ckPrev_q <= ckIn_q;
    adqIn_q  <= adq_i[7:0];
    maskIn_q <= dqs_i[0];
  end

  assign ckEdge = ckIn_q ^ ckPrev_q;
  assign addr_d = {addr_q[23:0], adqIn_q};
  assign ptr_d  = ptr_q + ADDR_W'(1);
  assign memRd  = mem[ptr_q];
  assign memWe  = !reset && !ceIn_q && ckEdge && !maskIn_q && (state_q == WDATA);

  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[ptr_q] <= adqIn_q;
    end
  end

  // ceSeenHigh_q arms IDLE->CMD, so a CE still low after reset is not mistaken for a new transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      isWrite_q    <= 1'b0;
      badCmd_q     <= 1'b0;
      ceSeenHigh_q <= 1'b0;
      adqOut_q     <= 8'h00;
      dqsOut_q     <= 2'b00;
      adqOe_q      <= 1'b0;
      dqsOe_q      <= 1'b0;
      cmdErr_q     <= 1'b0;
    end else begin
      cmdErr_q <= 1'b0;
      if (ceIn_q) begin
        ceSeenHigh_q <= 1'b1;
      end
      if (ceIn_q && (state_q != IDLE)) begin
        state_q  <= IDLE;
        adqOe_q  <= 1'b0;
        dqsOe_q  <= 1'b0;
        dqsOut_q <= 2'b00;
      end else begin
        case (state_q)
          IDLE: begin
            if (!ceIn_q && ceSeenHigh_q) begin
              cnt_q        <= '0;
              ceSeenHigh_q <= 1'b0;
              state_q      <= CMD;
            end
          end
          CMD: begin
            if (ckEdge) begin
              if (cnt_q == '0) begin
                cnt_q     <= CNT_W'(1);
                isWrite_q <= (adqIn_q == 8'h80);
                if ((adqIn_q != 8'h80) && (adqIn_q != 8'h00)) begin
                  badCmd_q <= 1'b1;
                  cmdErr_q <= 1'b1;
                end else begin
                  badCmd_q <= 1'b0;
                end
              end else begin
                cnt_q   <= '0;
                state_q <= badCmd_q ? IGNORE : ADDR;
              end
            end
          end
          ADDR: begin
            if (ckEdge) begin
              addr_q <= addr_d;
              if (cnt_q == CNT_W'(3)) begin
                ptr_q   <= addr_d[ADDR_W-1:0];
                cnt_q   <= '0;
                state_q <= isWrite_q ? WDATA : RLAT;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          WDATA: begin
            if (ckEdge) begin
              ptr_q <= ptr_d;
            end
          end
          RLAT: begin
            if (ckEdge) begin
              if (cnt_q == CNT_W'(READ_LAT - 1)) begin
                adqOe_q  <= 1'b1;
                dqsOe_q  <= 1'b1;
                dqsOut_q <= 2'b11;
                adqOut_q <= memRd;
                ptr_q    <= ptr_d;
                state_q  <= RDATA;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          RDATA: begin
            if (ckEdge) begin
              adqOut_q <= memRd;
              ptr_q    <= ptr_d;
              dqsOut_q <= ~dqsOut_q;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign adq_o   = adqOut_q;
  assign adq_oe  = adqOe_q;
  assign dqs_o   = dqsOut_q;
  assign dqs_oe  = dqsOe_q;
  assign cmd_err = cmdErr_q;
  assign state   = state_q;

  assign unused_bits = ^{adq_i[15:8], dqs_i[1], addr_q[31:24]};

endmodule
